// File: rtl/dac_pattern_player_if.sv
// Bundle of CSR command/status and AXI-stream sample signals for the DAC
// pattern player. The master modport is the player itself; the slave modport
// is the software/transport side that drives commands and accepts beats.
interface dac_pattern_player_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  sysCsrStrobe;
  logic [31:0]           GPIO_OUT;
  logic [31:0]           sysReadout;
  logic [DATA_WIDTH-1:0] axiData;
  logic                  axiValid;
  logic                  axiReady;

  modport master (
    input  sysCsrStrobe,
    input  GPIO_OUT,
    input  axiReady,
    output sysReadout,
    output axiData,
    output axiValid
  );

  modport slave (
    output sysCsrStrobe,
    output GPIO_OUT,
    output axiReady,
    input  sysReadout,
    input  axiData,
    input  axiValid
  );
endinterface

// File: rtl/dac_pattern_player.sv
// CSR-loaded arbitrary waveform source. Software pushes DAC samples one at a
// time into a beat-wide pattern buffer, then the block replays the buffer as
// AXI-stream beats, either looping forever or once (one-shot).
module dac_pattern_player #(
  parameter int AXI_CHANNEL_COUNT     = 2,
  parameter int AXI_SAMPLES_PER_CLOCK = 4,
  parameter int AXI_SAMPLE_WIDTH      = 16,
  parameter int DAC_WIDTH             = 14,
  parameter int DEPTH_LOG2            = 8
) (
  input logic                  sysClk,
  input logic                  sysReset,
  dac_pattern_player_if.master bus
);
  localparam int SPB        = AXI_CHANNEL_COUNT * AXI_SAMPLES_PER_CLOCK;
  localparam int DATA_WIDTH = SPB * AXI_SAMPLE_WIDTH;
  localparam int SPB_LOG2   = $clog2(SPB);
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int PTR_W      = DEPTH_LOG2 + SPB_LOG2 + 1;
  localparam int LEN_W      = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH * SPB);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    CMD_WRITE  = 2'b00,
    CMD_SETLEN = 2'b01,
    CMD_START  = 2'b10,
    CMD_STOP   = 2'b11
  } cmdT;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stateT;

  stateT state, stateNext;

  logic [DATA_WIDTH-1:0] patternMem [DEPTH];

  logic [LEN_W-1:0]      length;
  logic [PTR_W-1:0]      wrPtr;
  logic                  overflow;
  logic                  oneShot;
  logic                  stopPending;
  logic [DEPTH_LOG2-1:0] outIdx;
  logic [DEPTH_LOG2-1:0] nextIdx;
  logic [DATA_WIDTH-1:0] dataReg;
  logic                  validReg;
  logic [31:0]           readoutReg;

  cmdT                   cmd;
  logic                  writeCmd, setLenCmd, startCmd, stopCmd;
  logic                  isIdle, isRun, startOk, writeOk;
  logic                  handshake, lastBeat, finishBeat;
  logic                  loadFirst, loadNext, clearOut;
  logic [LEN_W-1:0]      newLen;
  logic [DEPTH_LOG2-1:0] wrBeat;
  int                    wrSlot;
  logic [AXI_SAMPLE_WIDTH-1:0] slotVal;
  logic                  unusedGpio;

  assign cmd       = cmdT'(bus.GPIO_OUT[31:30]);
  assign writeCmd  = bus.sysCsrStrobe && (cmd == CMD_WRITE);
  assign setLenCmd = bus.sysCsrStrobe && (cmd == CMD_SETLEN);
  assign startCmd  = bus.sysCsrStrobe && (cmd == CMD_START);
  assign stopCmd   = bus.sysCsrStrobe && (cmd == CMD_STOP);

  assign isIdle  = (state == IDLE);
  assign isRun   = (state == RUN);
  assign startOk = isIdle && startCmd && (length != '0);
  assign writeOk = isIdle && writeCmd && (wrPtr != PTR_FULL);
  assign newLen  = bus.GPIO_OUT[DEPTH_LOG2:0];

  assign handshake  = validReg && bus.axiReady;
  assign lastBeat   = ({1'b0, outIdx} == (length - LEN_W'(1)));
  assign finishBeat = stopPending || stopCmd || (oneShot && lastBeat);
  assign nextIdx    = lastBeat ? '0 : outIdx + DEPTH_LOG2'(1);

  assign wrBeat = wrPtr[PTR_W-2:SPB_LOG2];
  assign wrSlot = int'(wrPtr & PTR_W'(SPB - 1));

  assign unusedGpio = ^bus.GPIO_OUT[29:16];

  // Left-justify the incoming DAC code in its sample slot, low pad bits zero.
  always_comb begin
    slotVal = '0;
    slotVal[AXI_SAMPLE_WIDTH-1 -: DAC_WIDTH] = bus.GPIO_OUT[15 -: DAC_WIDTH];
  end

  // State register for the IDLE/RUN sequencer.
  always_ff @(posedge sysClk) begin
    if (sysReset) state <= IDLE;
    else          state <= stateNext;
  end

  // Next-state: start only with a non-empty pattern, stop on the final handshake.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (startOk) stateNext = RUN;
      RUN:  if (handshake && finishBeat) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output-stage controls: prime beat 0, advance on handshake, or retire the stream.
  always_comb begin
    loadFirst = 1'b0;
    loadNext  = 1'b0;
    clearOut  = 1'b0;
    if (isRun) begin
      loadFirst = !validReg;
      loadNext  = handshake && !finishBeat;
      clearOut  = handshake && finishBeat;
    end
  end

  // Sample writes into the pattern buffer; contents deliberately survive reset.
  always_ff @(posedge sysClk) begin
    if (writeOk && !sysReset)
      patternMem[wrBeat][wrSlot*AXI_SAMPLE_WIDTH +: AXI_SAMPLE_WIDTH] <= slotVal;
  end

  // CSR-visible control state: length, write pointer, overflow, mode and stop request.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      length      <= '0;
      wrPtr       <= '0;
      overflow    <= 1'b0;
      oneShot     <= 1'b0;
      stopPending <= 1'b0;
    end else begin
      if (isIdle && setLenCmd) begin
        if (newLen <= LEN_MAX) length <= newLen;
        wrPtr    <= '0;
        overflow <= 1'b0;
      end else if (isIdle && writeCmd) begin
        if (wrPtr == PTR_FULL) overflow <= 1'b1;
        else                   wrPtr    <= wrPtr + PTR_W'(1);
      end
      if (startOk) oneShot <= bus.GPIO_OUT[0];
      if (clearOut)             stopPending <= 1'b0;
      else if (isRun && stopCmd) stopPending <= 1'b1;
    end
  end

  // AXI output register: holds the beat steady until the consumer takes it.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      validReg <= 1'b0;
      dataReg  <= '0;
      outIdx   <= '0;
    end else if (loadFirst) begin
      validReg <= 1'b1;
      dataReg  <= patternMem[0];
      outIdx   <= '0;
    end else if (loadNext) begin
      dataReg  <= patternMem[nextIdx];
      outIdx   <= nextIdx;
    end else if (clearOut) begin
      validReg <= 1'b0;
      dataReg  <= '0;
    end
  end

  // Registered status word for software polling.
  always_ff @(posedge sysClk) begin
    if (sysReset) readoutReg <= '0;
    else readoutReg <= {isRun, oneShot, overflow, 2'b00, 11'(length), 16'(wrPtr)};
  end

  assign bus.axiData    = dataReg;
  assign bus.axiValid   = validReg;
  assign bus.sysReadout = readoutReg;
endmodule
